// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: write-side handshake, FIFO status and serial line of the UART transmitter.
interface uart_tx_param_if #(parameter int DATA_BITS = 8);
  logic                 Enable;
  logic [DATA_BITS-1:0] w_data;
  logic                 Full;
  logic                 Empty;
  logic                 Overrun;
  logic                 Busy;
  logic                 UART_TX_I;
  modport master (output Enable, w_data, input Full, Empty, Overrun, Busy, UART_TX_I);
  modport slave  (input Enable, w_data, output Full, Empty, Overrun, Busy, UART_TX_I);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable width, parity, stop bits and baud divisor.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input logic clk,
  input logic Resetn,
  uart_tx_param_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic [2:0]           state;
  logic [BW-1:0]        baud;
  logic [NW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift, head;
  logic                 par, tx, overrun;
  logic                 full, empty, bit_end, last_stop, push, pop;

  assign full      = count == CW'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign head      = mem[rd_ptr];
  assign bit_end   = baud == BAUD_LAST;
  assign last_stop = state == S_STOP && bit_end && bit_cnt == STOP_LAST;
  assign push      = bus.Enable && !full;
  assign pop       = !empty && (state == S_IDLE || last_stop);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.w_data;

  always_ff @(posedge clk or negedge Resetn)
    if (!Resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= bus.Enable && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end

  // tx is registered with the value belonging to the state being entered
  always_ff @(posedge clk or negedge Resetn)
    if (!Resetn) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      baud <= (state == S_IDLE || bit_end) ? '0 : baud + 1'b1;
      if (pop) begin
        shift   <= head;
        par     <= ^head ^ (PARITY == 1);
        bit_cnt <= '0;
        state   <= S_START;
        tx      <= 1'b0;
      end else begin
        case (state)
          S_START: if (bit_end) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
          S_DATA: if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= PARITY != 0 ? S_PARITY : S_STOP;
              tx      <= PARITY != 0 ? par : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
          S_PARITY: if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
          S_STOP: if (bit_end) begin
            if (bit_cnt == STOP_LAST) state <= S_IDLE;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end

  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.Overrun   = overrun;
  assign bus.Busy      = state != S_IDLE;
  assign bus.UART_TX_I = tx;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked every cycle against a frame-level model.
module tb_uart_tx_param;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] en = '0;
  logic [8:0] wd [4];
  logic [3:0] tx, bsy, emp, ful, ovr;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(8) b0 ();
  uart_tx_param_if #(8) b1 ();
  uart_tx_param_if #(8) b2 ();
  uart_tx_param_if #(5) b3 ();

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(6), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    d0 (.clk(clk), .Resetn(rst_n), .bus(b0));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(6), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8))
    d1 (.clk(clk), .Resetn(rst_n), .bus(b1));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(6), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8))
    d2 (.clk(clk), .Resetn(rst_n), .bus(b2));
  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(6), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8))
    d3 (.clk(clk), .Resetn(rst_n), .bus(b3));

  assign b0.Enable = en[0];
  assign b1.Enable = en[1];
  assign b2.Enable = en[2];
  assign b3.Enable = en[3];
  assign b0.w_data = wd[0][7:0];
  assign b1.w_data = wd[1][7:0];
  assign b2.w_data = wd[2][7:0];
  assign b3.w_data = wd[3][4:0];
  assign tx  = {b3.UART_TX_I, b2.UART_TX_I, b1.UART_TX_I, b0.UART_TX_I};
  assign bsy = {b3.Busy, b2.Busy, b1.Busy, b0.Busy};
  assign emp = {b3.Empty, b2.Empty, b1.Empty, b0.Empty};
  assign ful = {b3.Full, b2.Full, b1.Full, b0.Full};
  assign ovr = {b3.Overrun, b2.Overrun, b1.Overrun, b0.Overrun};

  function automatic int db(int i);  return i == 3 ? 5 : 8; endfunction
  function automatic int pm(int i);  return i == 1 ? 2 : (i == 2 ? 1 : 0); endfunction
  function automatic int sb(int i);  return i == 3 ? 2 : 1; endfunction
  function automatic int dep(int i); return i == 0 ? 4 : 8; endfunction
  function automatic int flen(int i); return (1 + db(i) + (pm(i) != 0 ? 1 : 0) + sb(i)) * 6; endfunction

  // bit k of a frame: start, data LSB first, optional parity, then stop bits
  function automatic logic fbit(int i, logic [8:0] w, int k);
    int ones = 0;
    if (k == 0) return 1'b0;
    if (k <= db(i)) return w[k-1];
    if (pm(i) != 0 && k == db(i) + 1) begin
      for (int j = 0; j < db(i); j++) ones += int'(w[j]);
      return (ones % 2 == 1) ^ (pm(i) == 1);
    end
    return 1'b1;
  endfunction

  // model: word queue plus position within the frame on air
  logic [8:0] mm [4][16];
  logic [8:0] cur [4];
  int hd [4], mc [4], el [4];
  logic [3:0] mb, mo;

  function automatic logic mpop(int i);  return mc[i] > 0 && (!mb[i] || el[i] == flen(i) - 1); endfunction
  function automatic logic mpush(int i); return en[i] && mc[i] < dep(i); endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mb <= '0;
      mo <= '0;
      for (int i = 0; i < 4; i++) begin
        hd[i] <= 0; mc[i] <= 0; el[i] <= 0; cur[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        mo[i] <= en[i] && mc[i] == dep(i);
        if (mpush(i)) mm[i][(hd[i] + mc[i]) % 16] <= wd[i];
        if (mpop(i)) begin
          cur[i] <= mm[i][hd[i] % 16];
          el[i]  <= 0;
          mb[i]  <= 1'b1;
          hd[i]  <= hd[i] + 1;
        end else if (mb[i]) begin
          el[i] <= el[i] + 1;
          if (el[i] == flen(i) - 1) mb[i] <= 1'b0;
        end
        mc[i] <= mc[i] + int'(mpush(i)) - int'(mpop(i));
      end
    end

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, i, a, e, $time);
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 4; i++) begin
      chk("line", i, 32'(tx[i]), 32'(mb[i] ? fbit(i, cur[i], el[i] / 6) : 1'b1));
      chk("busy", i, 32'(bsy[i]), 32'(mb[i]));
      chk("empty", i, 32'(emp[i]), 32'(mc[i] == 0));
      chk("full", i, 32'(ful[i]), 32'(mc[i] == dep(i)));
      chk("overrun", i, 32'(ovr[i]), 32'(mo[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  logic [9:0] s [4];
  int n [4];
  logic e0;

  task automatic frame(input logic [3:0] m, input logic [8:0] w, input logic [8:0] w3);
    en = m;
    for (int i = 0; i < 3; i++) wd[i] = w;
    wd[3] = w3;
    tick();
    en = '0;
    chk("empty_after_push", 0, 32'(emp[0]), 32'(!m[0]));
    for (int i = 0; i < 4; i++) begin s[i] = '0; n[i] = 0; end
    for (int c = 0; c < 80; c++) begin
      tick();
      if (c == 0) e0 = emp[0];
      for (int i = 0; i < 4; i++) begin
        if (bsy[i]) n[i]++;
        if (c % 6 == 3 && c < 60) s[i][c/6] = tx[i];
      end
    end
  endtask

  initial begin
    int nb, falls, lows, highs;
    logic pb;
    for (int i = 0; i < 4; i++) wd[i] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_line", 0, 32'(tx[0]), 1);
    chk("rst_busy", 0, 32'(bsy[0]), 0);
    chk("rst_empty", 0, 32'(emp[0]), 1);
    chk("rst_full", 0, 32'(ful[0]), 0);
    chk("rst_overrun", 0, 32'(ovr[0]), 0);
    rst_n = 1'b1;
    tick();
    frame(4'b1111, 9'h0A5, 9'h013);
    chk("bits_8n1", 0, 32'(s[0]), 32'b1101001010);
    chk("len_8n1", 0, n[0], 60);
    chk("empty_after_pop", 0, 32'(e0), 1);
    chk("parity_even_a5", 1, 32'(s[1][9]), 0);
    chk("parity_odd_a5", 2, 32'(s[2][9]), 1);
    chk("len_8e1", 1, n[1], 66);
    chk("len_8o1", 2, n[2], 66);
    chk("bits_5n2", 3, 32'(s[3][7:0]), 32'b11100110);
    chk("len_5n2", 3, n[3], 48);
    frame(4'b0110, 9'h007, 9'h000);
    chk("parity_even_07", 1, 32'(s[1][9]), 1);
    chk("parity_odd_07", 2, 32'(s[2][9]), 0);
    // six pushes into the depth-4 FIFO of dut0
    nb = 0; falls = 0;
    en[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      wd[0] = 9'(8'h30 + j);
      tick();
      if (bsy[0]) nb++;
      if (j == 4) chk("full_after_5", 0, 32'(ful[0]), 1);
      if (j == 4) chk("no_overrun_5", 0, 32'(ovr[0]), 0);
      if (j == 5) chk("overrun_6", 0, 32'(ovr[0]), 1);
    end
    en[0] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      pb = bsy[0];
      tick();
      if (bsy[0]) nb++;
      if (pb && !bsy[0]) falls++;
    end
    chk("burst_busy_cycles", 0, nb, 300);
    chk("burst_busy_falls", 0, falls, 1);
    // push coinciding with the pop at the last stop cycle, count 2
    en[0] = 1'b1;
    for (int j = 1; j <= 3; j++) begin wd[0] = 9'(8'h40 + j); tick(); end
    en[0] = 1'b0;
    for (int c = 0; c < 100 && el[0] != 59; c++) tick();
    chk("reach_last_stop", 0, el[0], 59);
    en[0] = 1'b1; wd[0] = 9'h044;
    tick();
    en[0] = 1'b0;
    chk("pushpop_empty", 0, 32'(emp[0]), 0);
    chk("pushpop_full", 0, 32'(ful[0]), 0);
    repeat (9) tick();
    chk("order_bit0_of_42", 0, 32'(tx[0]), 0);
    for (int c = 0; c < 400 && bsy[0]; c++) tick();
    chk("drained", 0, 32'(bsy[0]), 0);
    // reset during data bit 3 with two words still queued
    en[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin wd[0] = 9'(j); tick(); end
    en[0] = 1'b0;
    repeat (25) tick();
    chk("line_in_bit3", 0, 32'(tx[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_line", 0, 32'(tx[0]), 1);
    chk("async_busy", 0, 32'(bsy[0]), 0);
    chk("async_empty", 0, 32'(emp[0]), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    lows = 0; highs = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!tx[0]) lows++;
      if (bsy[0]) highs++;
    end
    chk("post_reset_lows", 0, lows, 0);
    chk("post_reset_busy", 0, highs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
